// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with wait states and error reporting
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic [15:0] addr_i,
   input  logic [15:0] data_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   output logic [15:0] data_o,
   output logic        ready_o,
   output logic        err_o,
   output logic        busy_o
);

   localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [15:0] DEPTH_C   = 16'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_C    = 4'(WAIT_CYCLES);
   localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic        rd_q;
   logic        wr_q;
   logic [15:0] data_q;
   logic        ready_q;
   logic        err_q;
   logic        busy_q;
   logic [15:0] mem_q [DEPTH_WORDS];

   logic [15:0]   sel_addr_d;
   logic [15:0]   sel_data_d;
   logic          sel_rd_d;
   logic          sel_wr_d;
   logic          sel_err_d;
   logic [AW-1:0] sel_idx_d;
   logic          req_d;
   logic          commit_d;

   // Pick the request being committed: live inputs for a zero-wait accept, latched copy otherwise
   always_comb begin
      req_d      = MemRead_i | MemWrite_i;
      sel_addr_d = addr_q;
      sel_data_d = wdata_q;
      sel_rd_d   = rd_q;
      sel_wr_d   = wr_q;
      if (state_q == S_IDLE) begin
         sel_addr_d = addr_i;
         sel_data_d = data_i;
         sel_rd_d   = MemRead_i;
         sel_wr_d   = MemWrite_i;
      end
      sel_err_d = sel_addr_d[0]
                | ({1'b0, sel_addr_d[15:1]} >= DEPTH_C)
                | (sel_rd_d & sel_wr_d);
      sel_idx_d = sel_addr_d[AW:1];
      commit_d  = ((state_q == S_IDLE) && req_d && ZERO_WAIT)
                | ((state_q == S_WAIT) && (cnt_q == 4'd0));
   end

   // Request FSM, wait counter, array commit and registered response outputs
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= 16'd0;
         wdata_q <= 16'd0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         data_q  <= 16'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= 16'd0;
         end
      end else begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;

         // The commit edge is the one that enters RESP; errors never touch the array or data_o
         if (commit_d) begin
            if (!sel_err_d && sel_wr_d) begin
               mem_q[sel_idx_d] <= sel_data_d;
            end
            if (!sel_err_d && sel_rd_d) begin
               data_q <= mem_q[sel_idx_d];
            end
            ready_q <= 1'b1;
            err_q   <= sel_err_d;
         end

         case (state_q)
            S_IDLE: begin
               if (req_d) begin
                  addr_q  <= addr_i;
                  wdata_q <= data_i;
                  rd_q    <= MemRead_i;
                  wr_q    <= MemWrite_i;
                  busy_q  <= 1'b1;
                  if (ZERO_WAIT) begin
                     state_q <= S_RESP;
                  end else begin
                     cnt_q   <= WAIT_C - 4'd1;
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_o  = data_q;
   assign ready_o = ready_q;
   assign err_o   = err_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with a behavioural memory model
module tb_dmem_responder;

   localparam int W_A   = 2;
   localparam int W_B   = 0;
   localparam int DEPTH = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] addr_a, data_a, dout_a;
   logic        rd_a, wr_a, ready_a, err_a, busy_a;
   logic [15:0] addr_b, data_b, dout_b;
   logic        rd_b, wr_b, ready_b, err_b, busy_b;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_A)) u_dut_a (
      .clk_i(clk), .rst_n(rst_n), .addr_i(addr_a), .data_i(data_a),
      .MemRead_i(rd_a), .MemWrite_i(wr_a), .data_o(dout_a),
      .ready_o(ready_a), .err_o(err_a), .busy_o(busy_a)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W_B)) u_dut_b (
      .clk_i(clk), .rst_n(rst_n), .addr_i(addr_b), .data_i(data_b),
      .MemRead_i(rd_b), .MemWrite_i(wr_b), .data_o(dout_b),
      .ready_o(ready_b), .err_o(err_b), .busy_o(busy_b)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        err;
      logic [15:0] dout;
      int          cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   logic [15:0] mmem [DEPTH];
   logic [15:0] mdout;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: one request applied to a word array, computed straight from the rules
   function automatic exp_t model(input logic rd, input logic wr, input logic [15:0] a,
                                  input logic [15:0] d, input int at_cyc);
      exp_t e;
      int   idx;
      idx   = int'(a) / 2;
      e.err = (a % 2 == 1) || (idx >= DEPTH) || (rd && wr);
      if (!e.err && wr) mmem[idx] = d;
      if (!e.err && rd) mdout = mmem[idx];
      e.dout = mdout;
      e.cyc  = at_cyc;
      return e;
   endfunction

   // Monitor for instance A: pop and compare on every response strobe
   always @(negedge clk) begin
      if (rst_n) begin
         if (ready_a) begin
            if (qa.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL a_spurious_ready: got ready 1 required 0 (cycle %0d)", cyc);
            end else begin
               ea = qa.pop_front();
               chk("a_data", 32'(dout_a), 32'(ea.dout));
               chk("a_err", 32'(err_a), 32'(ea.err));
               chk("a_latency", cyc, ea.cyc);
               chk("a_busy_resp", 32'(busy_a), 32'd1);
            end
         end else if (err_a) begin
            n_cmp++; n_fail++;
            $display("FAIL a_err_without_ready: got err 1 required 0 (cycle %0d)", cyc);
         end
      end
   end

   // Monitor for instance B (zero wait states)
   always @(negedge clk) begin
      if (rst_n) begin
         if (ready_b) begin
            if (qb.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL b_spurious_ready: got ready 1 required 0 (cycle %0d)", cyc);
            end else begin
               eb = qb.pop_front();
               chk("b_data", 32'(dout_b), 32'(eb.dout));
               chk("b_err", 32'(err_b), 32'(eb.err));
               chk("b_latency", cyc, eb.cyc);
               chk("b_busy_resp", 32'(busy_b), 32'd1);
            end
         end else if (err_b) begin
            n_cmp++; n_fail++;
            $display("FAIL b_err_without_ready: got err 1 required 0 (cycle %0d)", cyc);
         end
      end
   end

   task automatic chk_reset_outputs();
      chk("rst_data_a", 32'(dout_a), 32'd0);
      chk("rst_ready_a", 32'(ready_a), 32'd0);
      chk("rst_err_a", 32'(err_a), 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_data_b", 32'(dout_b), 32'd0);
      chk("rst_ready_b", 32'(ready_b), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);
   endtask

   // Issue one request to A, optionally scrambling addr/data while it waits
   task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input bit tog);
      int n;
      @(negedge clk);
      chk("a_busy_idle", 32'(busy_a), 32'd0);
      rd_a = rd; wr_a = wr; addr_a = a; data_a = d;
      qa.push_back(model(rd, wr, a, d, cyc + 1 + W_A));
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!ready_a) begin
            chk("a_busy_wait", 32'(busy_a), 32'd1);
            if (tog) begin
               addr_a = 16'($urandom);
               data_a = 16'($urandom);
            end
         end
      end while (!ready_a && n < W_A + 4);
      if (!ready_a) begin
         n_cmp++; n_fail++;
         $display("FAIL a_timeout: got no ready required ready within %0d cycles", W_A + 4);
         qa.delete();
      end
      rd_a = 1'b0; wr_a = 1'b0;
   endtask

   initial begin
      logic [15:0] a;
      logic        rd, wr;
      int          r;
      int          c0;

      rst_n = 1'b0;
      addr_a = '0; data_a = '0; rd_a = 1'b0; wr_a = 1'b0;
      addr_b = '0; data_b = '0; rd_b = 1'b0; wr_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) mmem[i] = 16'd0;
      mdout = 16'd0;

      repeat (2) begin
         @(negedge clk);
         chk_reset_outputs();
      end
      rst_n = 1'b1;

      do_req(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);

      // Zero-wait instance: one write, then a read held high for 20 cycles
      @(negedge clk);
      wr_b = 1'b1; addr_b = 16'h0002; data_b = 16'hC0DE;
      qb.push_back('{err: 1'b0, dout: 16'h0000, cyc: cyc + 1});
      @(negedge clk);
      wr_b = 1'b0;
      @(negedge clk);
      c0 = cyc;
      rd_b = 1'b1;
      for (int i = 0; i < 10; i++) qb.push_back('{err: 1'b0, dout: 16'hC0DE, cyc: c0 + 1 + 2 * i});
      repeat (20) @(negedge clk);
      rd_b = 1'b0;

      // Directed cases on the two-wait-state instance
      do_req(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
      do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      do_req(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
      do_req(1'b0, 1'b1, 16'h0080, 16'hDEAD, 1'b0);
      do_req(1'b1, 1'b1, 16'h0010, 16'h1111, 1'b0);
      do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
      do_req(1'b0, 1'b1, 16'h0008, 16'h5A5A, 1'b1);
      do_req(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0);
      do_req(1'b0, 1'b1, 16'h007E, 16'h7E7E, 1'b0);
      do_req(1'b1, 1'b0, 16'h007E, 16'h0000, 1'b0);

      // Reset during the wait of a write: no response, write never lands
      @(negedge clk);
      wr_a = 1'b1; addr_a = 16'h0020; data_a = 16'h1234;
      @(negedge clk);
      rst_n = 1'b0; wr_a = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk_reset_outputs();
      end
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) mmem[i] = 16'd0;
      mdout = 16'd0;
      do_req(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

      // Randomized traffic
      for (int k = 0; k < 150; k++) begin
         r  = $urandom_range(0, 9);
         rd = (r <= 4);
         wr = (r == 0) || (r >= 5);
         a  = 16'($urandom_range(0, 70)) << 1;
         if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
         if ($urandom_range(0, 19) == 0) a = 16'($urandom);
         do_req(rd, wr, a, 16'($urandom), ($urandom_range(0, 3) == 0));
      end

      // Sweep every word to confirm no stray array modification
      for (int i = 0; i < DEPTH; i++) begin
         do_req(1'b1, 1'b0, 16'(i * 2), 16'h0000, 1'b0);
      end

      repeat (5) @(negedge clk);
      chk("a_queue_drained", qa.size(), 32'd0);
      chk("b_queue_drained", qb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
